// File: rtl/hsv_core_div.sv
// Iterative RV M-extension divide unit (DIV/DIVU/REM/REMU) with restoring
// shift-subtract, sink/source handshake, flush req-ack and an output skid buffer.

package hsv_core_div_pkg;
   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t       pc;
      word_t       pc_increment;
      logic [4:0]  rd;
   } common_t;

   // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
   typedef struct packed {
      common_t     common;
      word_t       dividend;
      word_t       divisor;
      logic [1:0]  op;
   } div_data_t;

   typedef struct packed {
      logic        jump;
      logic        trap;
      common_t     common;
      word_t       result;
      logic        writeback;
      word_t       next_pc;
   } commit_data_t;
endpackage

module hs_skid_buffer #(
   parameter type T = logic
) (
   input  logic clk_core,
   input  logic rst_core_n,
   input  logic flush,
   input  T     in_data,
   input  logic in_valid,
   output logic in_ready,
   output T     out_data,
   output logic out_valid,
   input  logic out_ready
);
   logic full_q;
   T     buf_q;

   // Pass-through while empty; the buffer only fills when the sink stalls.
   assign in_ready  = ~full_q;
   assign out_valid = ~flush & (full_q | in_valid);
   assign out_data  = full_q ? buf_q : in_data;

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n)                   full_q <= 1'b0;
      else if (flush)                    full_q <= 1'b0;
      else if (full_q)                   full_q <= ~out_ready;
      else if (in_valid && !out_ready)   full_q <= 1'b1;
   end

   always_ff @(posedge clk_core) begin
      if (!full_q && in_valid) buf_q <= in_data;
   end
endmodule

module hsv_core_div
   import hsv_core_div_pkg::*;
#(
   parameter int XLEN           = hsv_core_div_pkg::XLEN,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic         clk_core,
   input  logic         rst_core_n,
   input  logic         flush_req,
   output logic         flush_ack,
   input  div_data_t    div_data,
   output logic         ready_o,
   input  logic         valid_i,
   output commit_data_t commit_data,
   input  logic         ready_i,
   output logic         valid_o
);
   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
   logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix;
   logic [XLEN-1:0] a_abs, b_abs, special_res;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      op_q;
   common_t         common_q;
   logic            q_neg_q, r_neg_q;
   logic            signed_op, a_neg, b_neg, div_zero, ovf, special;
   logic            accept, last_iter, out_valid, out_ready;
   commit_data_t    out_data;

   assign signed_op = ~div_data.op[0];
   assign a_neg     = signed_op & div_data.dividend[XLEN-1];
   assign b_neg     = signed_op & div_data.divisor[XLEN-1];
   assign a_abs     = a_neg ? -div_data.dividend : div_data.dividend;
   assign b_abs     = b_neg ? -div_data.divisor  : div_data.divisor;
   assign div_zero  = (div_data.divisor == '0);
   assign ovf       = signed_op & (div_data.dividend == {1'b1, {(XLEN-1){1'b0}}})
                      & (&div_data.divisor);
   assign special   = div_zero | ovf;

   // Both special cases reduce to "all ones / dividend / zero" selections.
   always_comb begin
      special_res = '0;
      if (div_data.op[1]) special_res = div_zero ? div_data.dividend : '0;
      else                special_res = div_zero ? '1 : div_data.dividend;
   end

   always_comb begin
      logic [XLEN:0]   r_ext;
      logic [XLEN-1:0] r, q;
      r     = rem_q;
      q     = quo_q;
      r_ext = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         r_ext = {r, q[XLEN-1]};
         q     = {q[XLEN-2:0], 1'b0};
         if (r_ext >= {1'b0, dvs_q}) begin
            r_ext = r_ext - {1'b0, dvs_q};
            q[0]  = 1'b1;
         end
         r = r_ext[XLEN-1:0];
      end
      rem_nx = r;
      quo_nx = q;
   end

   assign quo_fix   = q_neg_q ? -quo_nx : quo_nx;
   assign rem_fix   = r_neg_q ? -rem_nx : rem_nx;
   assign last_iter = (cnt_q == CW'(N - 1));
   assign accept    = valid_i & ready_o;

   always_ff @(posedge clk_core) begin
      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ready_o   = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            ready_o = ~flush_req & out_ready;
            if (valid_i && ready_o) state_d = special ? DONE : CALC;
         end
         CALC: if (last_iter) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_req) state_d = IDLE;
   end

   always_ff @(posedge clk_core) begin
      if (accept) begin
         op_q     <= div_data.op;
         common_q <= div_data.common;
         q_neg_q  <= a_neg ^ b_neg;
         r_neg_q  <= a_neg;
         dvs_q    <= b_abs;
         quo_q    <= a_abs;
         rem_q    <= '0;
         cnt_q    <= '0;
         res_q    <= special_res;
      end else if (state_q == CALC) begin
         quo_q <= quo_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + CW'(1);
         if (last_iter) res_q <= op_q[1] ? rem_fix : quo_fix;
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) flush_ack <= 1'b1;
      else             flush_ack <= flush_req;
   end

   always_comb begin
      out_data           = '0;
      out_data.jump      = 1'b0;
      out_data.trap      = 1'b0;
      out_data.common    = common_q;
      out_data.result    = res_q;
      out_data.writeback = 1'b1;
      out_data.next_pc   = common_q.pc_increment;
   end

   hs_skid_buffer #(.T(commit_data_t)) u_skid (
      .clk_core   (clk_core),
      .rst_core_n (rst_core_n),
      .flush      (flush_req),
      .in_data    (out_data),
      .in_valid   (out_valid),
      .in_ready   (out_ready),
      .out_data   (commit_data),
      .out_valid  (valid_o),
      .out_ready  (ready_i)
   );
endmodule

// File: tb/tb_hsv_core_div.sv
module tb_hsv_core_div;
  import hsv_core_div_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_req;
  logic         ready_i;
  logic         v1, v4;
  div_data_t    dd;
  common_t      cmn;
  logic         ack1, ack4, rdy1, rdy4, vo1, vo4;
  commit_data_t cd1, cd4, saved;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           lat;
  logic [31:0]  res;

  always #5 clk = ~clk;

  hsv_core_div #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush_req), .flush_ack(ack1),
    .div_data(dd), .ready_o(rdy1), .valid_i(v1), .commit_data(cd1),
    .ready_i(ready_i), .valid_o(vo1)
  );

  hsv_core_div #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush_req), .flush_ack(ack4),
    .div_data(dd), .ready_o(rdy4), .valid_i(v4), .commit_data(cd4),
    .ready_i(ready_i), .valid_o(vo4)
  );

  task automatic chk(input string tag, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use4, output int cyc, output logic [31:0] r);
    int w;
    dd.op = op; dd.dividend = a; dd.divisor = b; dd.common = cmn;
    if (use4) v4 = 1'b1; else v1 = 1'b1;
    w = 0;
    while (!(use4 ? rdy4 : rdy1) && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    v1 = 1'b0; v4 = 1'b0;
    cyc = 1;
    while (!(use4 ? vo4 : vo1) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    r = use4 ? cd4.result : cd1.result;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit use4, input logic [31:0] exp_r,
                     input int exp_lat);
    int          c;
    logic [31:0] r;
    issue(op, a, b, use4, c, r);
    chk({tag, "_result"}, r === exp_r);
    chk({tag, "_latency"}, c === exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    cmn = '{pc: 32'h100, pc_increment: 32'h104, rd: 5'd5};
    dd = '0; v1 = 0; v4 = 0; ready_i = 1; flush_req = 1; rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_flush_ack", ack1 === 1'b1);
    chk("rst_valid_o", vo1 === 1'b0);
    chk("rst_valid_o4", vo4 === 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ack", ack1 === 1'b1);
    chk("flush_ready_low", rdy1 === 1'b0);
    flush_req = 0;
    @(posedge clk); #1;
    chk("ack_release", ack1 === 1'b0);
    chk("idle_ready", rdy1 === 1'b1);

    issue(2'b01, 32'd100, 32'd7, 1'b0, lat, res);
    chk("divu_result", res === 32'd14);
    chk("divu_latency", lat === 33);
    chk("divu_wb", cd1.writeback === 1'b1);
    chk("divu_jump", cd1.jump === 1'b0);
    chk("divu_trap", cd1.trap === 1'b0);
    chk("divu_next_pc", cd1.next_pc === 32'h104);
    chk("divu_common", cd1.common === cmn);
    @(posedge clk); #1;

    run("div_neg",  2'b00, 32'hFFFFFF9C, 32'd7, 1'b0, 32'hFFFFFFF2, 33);
    run("rem_neg",  2'b10, 32'hFFFFFF9C, 32'd7, 1'b0, 32'hFFFFFFFE, 33);
    run("div_negb", 2'b00, 32'd100, 32'hFFFFFFF9, 1'b0, 32'hFFFFFFF2, 33);
    run("div_zero", 2'b00, 32'h55, 32'd0, 1'b0, 32'hFFFFFFFF, 1);
    run("remu_zero", 2'b11, 32'h1234, 32'd0, 1'b0, 32'h1234, 1);
    run("div_ovf",  2'b00, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1);
    run("rem_ovf",  2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 1);
    run("divu_big", 2'b01, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h1, 33);

    dd.op = 2'b01; dd.dividend = 32'd100; dd.divisor = 32'd7; dd.common = cmn;
    v1 = 1;
    @(posedge clk); #1;
    v1 = 0;
    repeat (10) @(posedge clk);
    #1 flush_req = 1;
    chk("flush_ready_o", rdy1 === 1'b0);
    chk("flush_ack_before", ack1 === 1'b0);
    @(posedge clk); #1;
    chk("flush_ack_rise", ack1 === 1'b1);
    chk("flush_ready_hold", rdy1 === 1'b0);
    repeat (2) @(posedge clk);
    #1 flush_req = 0;
    chk("flush_ack_hold", ack1 === 1'b1);
    @(posedge clk); #1;
    chk("flush_ack_fall", ack1 === 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (vo1) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", seen === 0);
    run("divu_after_flush", 2'b01, 32'd9, 32'd3, 1'b0, 32'd3, 33);

    ready_i = 0;
    issue(2'b11, 32'd100, 32'd7, 1'b0, lat, res);
    chk("bp_result", res === 32'd2);
    chk("bp_latency", lat === 33);
    saved = cd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", vo1 === 1'b1);
      chk("bp_data_stable", cd1 === saved);
      chk("bp_ready_low", rdy1 === 1'b0);
    end
    ready_i = 1;
    @(posedge clk); #1;
    chk("bp_valid_drop", vo1 === 1'b0);
    chk("bp_ready_back", rdy1 === 1'b1);

    run("bpc4_divu", 2'b01, 32'hFFFFFFFF, 32'h10, 1'b1, 32'h0FFFFFFF, 9);
    run("bpc4_remu", 2'b11, 32'hFFFFFFFF, 32'h10, 1'b1, 32'hF, 9);
    run("bpc4_div",  2'b00, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
